// File: rtl/clk_div_gen_pkg.sv
// Shared types, constants and helpers for the multi-channel clock divider/enable generator.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF = 8;
    localparam int unsigned DIV_OFF   = 0;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// Divisor-configuration handshake between a programming agent and clk_div_gen.
interface clk_div_gen_if
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV_W  = DIV_W_DEF
);
    localparam int unsigned CH_W = sel_w(NUM_CH);

    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_gen_ch.sv
// One divider channel: period counter, active/pending divisor and registered outputs.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load_req,
    input  logic [DIV_W-1:0] load_div,
    output logic             pend_vld,
    output logic             clk_en_o,
    output logic             clk_div_o
);

    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] DIV_PARK = DIV_W'(DIV_OFF);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_en_q, clk_en_d;
    logic             clk_div_q, clk_div_d;

    logic             run_c;
    logic             term_c;
    logic             wrap_c;
    logic [DIV_W:0]   half_c;

    // A disabled or parked channel sits at count 0, so it wraps (and can adopt a pending divisor) every cycle.
    always_comb begin
        run_c  = en && (div_q != DIV_PARK);
        term_c = run_c && (cnt_q == (div_q - DIV_W'(1)));
        wrap_c = sync || term_c || !run_c;
        half_c = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    end

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        clk_en_d   = 1'b0;
        clk_div_d  = 1'b0;

        if (wrap_c) begin
            cnt_d = '0;
            if (pend_vld_q) begin
                div_d      = pend_div_q;
                pend_vld_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end

        if (load_req) begin
            pend_div_d = load_div;
            pend_vld_d = 1'b1;
        end

        // High phase covers ceil(div/2) counts, so odd divisors favour the high phase.
        if (run_c) begin
            clk_en_d  = term_c;
            clk_div_d = ({1'b0, cnt_q} < half_c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            div_q      <= DIV_RST;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            clk_en_q   <= 1'b0;
            clk_div_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            clk_en_q   <= clk_en_d;
            clk_div_q  <= clk_div_d;
        end
    end

    assign pend_vld  = pend_vld_q;
    assign clk_en_o  = clk_en_q;
    assign clk_div_o = clk_div_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator with glitch-free runtime divisor updates.
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = DIV_W_DEF,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] clk_div_o
);

    localparam int unsigned CH_W = sel_w(NUM_CH);

    logic [NUM_CH-1:0] pend_vld;
    logic [NUM_CH-1:0] load_req_c;
    logic              ready_c;

    // Ready depends only on the selected channel's pending flag; out-of-range selects are always ready.
    always_comb begin
        ready_c = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((cfg.cfg_ch == CH_W'(i)) && pend_vld[i]) begin
                ready_c = 1'b0;
            end
        end
    end

    assign cfg.cfg_ready = ready_c;

    always_comb begin
        load_req_c = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_req_c[i] = cfg.cfg_valid && ready_c && (cfg.cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .en        (ch_en[g]),
            .sync      (sync),
            .load_req  (load_req_c[g]),
            .load_div  (cfg.cfg_div),
            .pend_vld  (pend_vld[g]),
            .clk_en_o  (clk_en_o[g]),
            .clk_div_o (clk_div_o[g])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen: per-cycle waveform scoreboard plus hand-derived spot checks.
module tb_clk_div_gen;
    import clk_div_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DEF = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] ch_en;
    logic           sync;
    logic [NCH-1:0] clk_en_o;
    logic [NCH-1:0] clk_div_o;

    clk_div_gen_if #(.NUM_CH(NCH), .DIV_W(DW)) cfg ();

    clk_div_gen #(
        .NUM_CH  (NCH),
        .DIV_W   (DW),
        .DEF_DIV (DEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ch_en     (ch_en),
        .sync      (sync),
        .cfg       (cfg),
        .clk_en_o  (clk_en_o),
        .clk_div_o (clk_div_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] en;
        logic [NCH-1:0] dv;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   n      = 0;
    int   s_edge = 0;
    int   a_edge = 0;
    int   d   [NCH];
    int   pd  [NCH];
    int   t0  [NCH];
    bit   pend[NCH];
    exp_t sbq [$];
    int   coin[$];
    logic [3:0] en_w;
    logic [3:0] dv_w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waveform model: each channel is a period of d cycles starting at output edge t0.
    task automatic model_reset();
        n = 0;
        for (int i = 0; i < NCH; i++) begin
            d[i]    = DEF;
            pd[i]   = 0;
            pend[i] = 1'b0;
            t0[i]   = 1;
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t got;
        bit   rdy;
        bit   run;
        bit   term;
        int   m;
        int   ch;
        #1;
        ch  = int'(cfg.cfg_ch);
        rdy = !pend[ch];
        chk($sformatf("cfg_ready@%0d", n + 1), 32'(cfg.cfg_ready), 32'(rdy));
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            run  = ch_en[i] && (d[i] != 0);
            term = 1'b0;
            if (run) begin
                m        = (n + 1 - t0[i]) % d[i];
                e.dv[i]  = (m < (d[i] + 1) / 2);
                e.en[i]  = (m == d[i] - 1);
                term     = (m == d[i] - 1);
            end
            if (sync || !run || term) begin
                t0[i] = n + 2;
                if (pend[i]) begin
                    d[i]    = pd[i];
                    pend[i] = 1'b0;
                end
            end
        end
        if (cfg.cfg_valid && rdy) begin
            pend[ch] = 1'b1;
            pd[ch]   = int'(cfg.cfg_div);
        end
        sbq.push_back(e);
        @(posedge clk);
        n++;
        #1;
        got = sbq.pop_front();
        chk($sformatf("clk_en_o@%0d", n),  32'(clk_en_o),  32'(got.en));
        chk($sformatf("clk_div_o@%0d", n), 32'(clk_div_o), 32'(got.dv));
    endtask

    task automatic cfg_req(input int ch, input int dv);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_ch    = 2'(ch);
        cfg.cfg_div   = div_t'(dv);
        step();
        cfg.cfg_valid = 1'b0;
    endtask

    initial begin
        ch_en         = '1;
        sync          = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_ch    = '0;
        cfg.cfg_div   = '0;

        // Reset: everything quiet, ready high.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clk_en",  32'(clk_en_o),  0);
        chk("rst_clk_div", 32'(clk_div_o), 0);
        chk("rst_ready",   32'(cfg.cfg_ready), 1);
        rst = 1'b0;
        model_reset();

        // Default divide-by-2 on all channels; first strobe on the second edge.
        step();
        chk("first_en_edge1", 32'(clk_en_o), 0);
        step();
        chk("first_en_edge2", 32'(clk_en_o), 32'hF);
        repeat (4) step();

        // ch1 -> 5 mid-period, ready for ch1 held low until the apply.
        cfg.cfg_ch = 2'd1;
        step();
        cfg_req(1, 5);
        repeat (14) step();

        // ch0 -> 3, ch2 -> 7, then sync; strobes of ch0/ch2 coincide every 21 cycles.
        cfg_req(0, 3);
        cfg_req(2, 7);
        sync = 1'b1;
        step();
        sync   = 1'b0;
        s_edge = n;
        coin.delete();
        repeat (45) begin
            step();
            if (clk_en_o[0] && clk_en_o[2]) coin.push_back(n);
        end
        chk("coin_count", 32'(coin.size()), 2);
        if (coin.size() == 2) begin
            chk("coin_first", 32'(coin[0] - s_edge), 21);
            chk("coin_gap",   32'(coin[1] - coin[0]), 21);
        end

        // ch3 parked, then divide-by-1: constant high two edges after the accept.
        cfg_req(3, 0);
        repeat (4) step();
        cfg.cfg_ch = 2'd3;
        step();
        cfg_req(3, 1);
        a_edge = n;
        step();
        chk("ch3_apply_edge", 32'({clk_en_o[3], clk_div_o[3]}), 0);
        step();
        chk("ch3_on_delay", 32'(n - a_edge), 2);
        chk("ch3_on", 32'({clk_en_o[3], clk_div_o[3]}), 32'b11);
        repeat (3) begin
            step();
            chk("ch3_const", 32'({clk_en_o[3], clk_div_o[3]}), 32'b11);
        end

        // ch1 -> 4, disable for 4 cycles, re-enable restarts with the high phase.
        cfg_req(1, 4);
        repeat (8) step();
        ch_en[1] = 1'b0;
        repeat (4) begin
            step();
            chk("ch1_off", 32'({clk_en_o[1], clk_div_o[1]}), 0);
        end
        ch_en[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            en_w[k] = clk_en_o[1];
            dv_w[k] = clk_div_o[1];
        end
        chk("reen_div", 32'(dv_w), 32'b0011);
        chk("reen_en",  32'(en_w), 32'b1000);
        repeat (4) step();

        // Reset mid-period with ch2 update pending: update lost, no stray strobe.
        cfg.cfg_ch = 2'd2;
        cfg_req(2, 9);
        #1;
        chk("pend_before_rst", 32'(cfg.cfg_ready), 0);
        rst = 1'b1;
        #1;
        chk("midrst_clk_en",  32'(clk_en_o),  0);
        chk("midrst_clk_div", 32'(clk_div_o), 0);
        chk("midrst_ready",   32'(cfg.cfg_ready), 1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("inrst_outputs", 32'({clk_en_o, clk_div_o}), 0);
        end
        rst = 1'b0;
        model_reset();
        repeat (8) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
